// File: rtl/srt_pkg.sv
// Shared definitions for the SRT quotient converter: digit encodings, FSM states
// and the default quotient width.
package srt_pkg;

  localparam int NDIG_DEFAULT = 32;

  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_NEG  = 2'b11;
  localparam logic [1:0] DIG_ILL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/srt_otf_reg.sv
// On-the-fly conversion register pair: Q and QM = Q-1 are both shifted per digit,
// so the final quotient never needs a carry-propagate adder.
module srt_otf_reg
  import srt_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            clr,
  input  logic            en,
  input  logic [1:0]      dig,
  output logic [NDIG-1:0] q,
  output logic [NDIG-1:0] qm
);

  // Both registers start at zero; the stale upper bits are shifted out after NDIG
  // digits, so Q/QM are exact once the conversion completes.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      q  <= '0;
      qm <= '0;
    end else if (en) begin
      case (dig)
        DIG_POS: begin
          q  <= {q[NDIG-2:0], 1'b1};
          qm <= {q[NDIG-2:0], 1'b0};
        end
        DIG_NEG: begin
          q  <= {qm[NDIG-2:0], 1'b1};
          qm <= {qm[NDIG-2:0], 1'b0};
        end
        default: begin
          q  <= {q[NDIG-2:0], 1'b0};
          qm <= {qm[NDIG-2:0], 1'b1};
        end
      endcase
    end
  end

endmodule

// File: rtl/srt_qconv.sv
// SRT quotient converter: collects NDIG signed radix-2 digits, then applies the
// negative-remainder correction and presents Q/R on a valid/ready output.
module srt_qconv
  import srt_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [NDIG-1:0] DSR,
  input  logic            DIG_VALID,
  output logic            DIG_READY,
  input  logic [1:0]      DIG,
  input  logic [NDIG:0]   PREM,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [NDIG-1:0] Q,
  output logic [NDIG-1:0] R,
  output logic            ERR,
  output state_t          DBG_STATE
);

  // Handshakes: a digit transfers on a rising edge where DIG_VALID && DIG_READY;
  // a result transfers on a rising edge where OUT_VALID && OUT_READY.
  localparam int CW = $clog2(NDIG + 1);

  state_t            state, state_n;
  logic [NDIG-1:0]   dsr_r, q_r, r_r, otf_q, otf_qm, r_corr;
  logic [NDIG:0]     prem_r;
  logic [CW-1:0]     cnt;
  logic              err_r, start_acc, dig_acc, last_dig;

  assign DIG_READY = (state == CONV);
  assign OUT_VALID = (state == DONE);
  assign dig_acc   = DIG_VALID && DIG_READY;
  assign last_dig  = (cnt == CW'(NDIG - 1));
  assign r_corr    = prem_r[NDIG] ? (prem_r[NDIG-1:0] + dsr_r) : prem_r[NDIG-1:0];
  assign Q         = q_r;
  assign R         = r_r;
  assign ERR       = err_r;
  assign DBG_STATE = state;

  srt_otf_reg #(.NDIG(NDIG)) u_otf (
    .CLK (CLK),
    .RST (RST),
    .clr (start_acc),
    .en  (dig_acc),
    .dig (DIG),
    .q   (otf_q),
    .qm  (otf_qm)
  );

  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          start_acc = 1'b1;
          state_n   = CONV;
        end
      end
      CONV: begin
        if (dig_acc && last_dig) state_n = CORR;
      end
      CORR: state_n = DONE;
      DONE: begin
        if (OUT_READY) begin
          start_acc = START;
          state_n   = START ? CONV : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      dsr_r  <= '0;
      prem_r <= '0;
      cnt    <= '0;
      q_r    <= '0;
      r_r    <= '0;
      err_r  <= 1'b0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        dsr_r <= DSR;
        cnt   <= '0;
        err_r <= 1'b0;
      end else if (dig_acc) begin
        cnt <= cnt + CW'(1);
        if (DIG == DIG_ILL) err_r <= 1'b1;
        if (last_dig) prem_r <= PREM;
      end
      // A negative final remainder means the quotient overshot by one.
      if (state == CORR) begin
        q_r <= prem_r[NDIG] ? otf_qm : otf_q;
        r_r <= r_corr;
      end
    end
  end

endmodule

// File: tb/tb_srt_qconv.sv
// Self-checking bench for srt_qconv: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_srt_qconv;
  import srt_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST, START, DIG_VALID, OUT_READY;
  logic         DIG_READY, OUT_VALID, ERR;
  logic [W-1:0] DSR, Q, R;
  logic [1:0]   DIG;
  logic [W:0]   PREM;
  state_t       dbg_state;

  int           n_vec = 0;
  int           n_err = 0;
  logic [1:0]   dig_mem [W];
  logic [W-1:0] exp_q[$];
  logic         exp_err;

  always #5 CLK = ~CLK;

  srt_qconv #(.NDIG(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .DSR       (DSR),
    .DIG_VALID (DIG_VALID),
    .DIG_READY (DIG_READY),
    .DIG       (DIG),
    .PREM      (PREM),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Q         (Q),
    .R         (R),
    .ERR       (ERR),
    .DBG_STATE (dbg_state)
  );

  // Reference: quotient is the weighted digit sum; a negative remainder moves
  // one divisor from the quotient back into the remainder.
  task automatic model(input logic [W-1:0] dsr, input logic [W:0] prem);
    longint qv = 0;
    longint pv;
    logic   e = 1'b0;
    for (int i = 0; i < W; i++) begin
      qv = qv * 2;
      if (dig_mem[i] == 2'b01) qv = qv + 1;
      else if (dig_mem[i] == 2'b11) qv = qv - 1;
      else if (dig_mem[i] == 2'b10) e = 1'b1;
    end
    pv = longint'($signed(prem));
    if (pv < 0) begin
      qv = qv - 1;
      pv = pv + longint'(dsr);
    end
    exp_q.push_back(W'(qv));
    exp_q.push_back(W'(pv));
    exp_err = e;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_start(input logic [W-1:0] dsr);
    START = 1'b1;
    DSR   = dsr;
    tick();
    START = 1'b0;
    DSR   = $urandom;
  endtask

  task automatic send_digits(input int n, input logic [W:0] prem, input bit gaps,
                             input bit poke_start, output int bad_ready);
    bad_ready = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          DIG_VALID = 1'b0;
          DIG       = 2'($urandom);
          tick();
        end
      end
      DIG_VALID = 1'b1;
      DIG       = dig_mem[i];
      PREM      = (i == W - 1) ? prem : {1'($urandom), 32'($urandom)};
      START     = poke_start && ($urandom_range(0, 1) == 1);
      if (DIG_READY !== 1'b1) bad_ready++;
      tick();
    end
    DIG_VALID = 1'b0;
    START     = 1'b0;
    PREM      = {1'($urandom), 32'($urandom)};
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (OUT_VALID !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic set_digits_74_21;
    for (int i = 0; i < W; i++) dig_mem[i] = 2'b00;
    dig_mem[30] = 2'b01;
    dig_mem[31] = 2'b01;
  endtask

  task automatic test_reset;
    RST = 1'b1; START = 1'b1; DIG_VALID = 1'b1; OUT_READY = 1'b1;
    tick();
    tick();
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
    n_vec++; if (DIG_READY !== 1'b0) begin n_err++; $display("FAIL reset_dig_ready: got %b want 0", DIG_READY); end
    n_vec++; if (Q !== '0) begin n_err++; $display("FAIL reset_q: got %h want 0", Q); end
    n_vec++; if (R !== '0) begin n_err++; $display("FAIL reset_r: got %h want 0", R); end
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", ERR); end
    RST = 1'b0; START = 1'b0; DIG_VALID = 1'b0; OUT_READY = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    int bad, lat;
    logic [W-1:0] dsr_t [4] = '{32'd21, 32'd21, 32'd5, 32'd5};
    logic [W:0]   prem_t[4] = '{33'd11, 33'h1_FFFF_FFF6, 33'd2, 33'd0};
    logic [W-1:0] q_t   [4] = '{32'd3, 32'd3, 32'd1, 32'd1};
    logic [W-1:0] r_t   [4] = '{32'd11, 32'd11, 32'd2, 32'd0};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < W; i++) dig_mem[i] = (c == 3) ? 2'b11 : 2'b00;
      case (c)
        0: begin dig_mem[30] = 2'b01; dig_mem[31] = 2'b01; end
        1: dig_mem[29] = 2'b01;
        2: begin dig_mem[30] = 2'b01; dig_mem[31] = 2'b11; end
        default: dig_mem[0] = 2'b01;
      endcase
      drive_start(dsr_t[c]);
      send_digits(W, prem_t[c], 1'b0, 1'b0, bad);
      wait_out(lat);
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL directed%0d_latency: got %0d want 1", c, lat); end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL directed%0d_dig_ready: got %0d stalls want 0", c, bad); end
      n_vec++; if (Q !== q_t[c]) begin n_err++; $display("FAIL directed%0d_q: got %0d want %0d", c, Q, q_t[c]); end
      n_vec++; if (R !== r_t[c]) begin n_err++; $display("FAIL directed%0d_r: got %0d want %0d", c, R, r_t[c]); end
      n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL directed%0d_err: got %b want 0", c, ERR); end
      release_out();
    end
  endtask

  task automatic test_random;
    int bad, lat, r;
    logic [W-1:0] dsr, eq, er;
    logic [W:0]   prem;
    for (int op = 0; op < 20; op++) begin
      dsr = $urandom;
      if (dsr == '0) dsr = 1;
      prem = {1'($urandom), 32'($urandom)};
      for (int i = 0; i < W; i++) begin
        r = $urandom_range(0, 19);
        dig_mem[i] = (r == 0) ? 2'b10 : (r % 3 == 0) ? 2'b00 : (r % 3 == 1) ? 2'b01 : 2'b11;
      end
      model(dsr, prem);
      DIG_VALID = 1'b1;
      DIG       = 2'b01;
      tick();
      DIG_VALID = 1'b0;
      drive_start(dsr);
      send_digits(W, prem, 1'b1, 1'b1, bad);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) tick();
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL rand%0d_latency: got %0d want 1", op, lat); end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rand%0d_dig_ready: got %0d stalls want 0", op, bad); end
      n_vec++; if (Q !== eq) begin n_err++; $display("FAIL rand%0d_q: got %h want %h", op, Q, eq); end
      n_vec++; if (R !== er) begin n_err++; $display("FAIL rand%0d_r: got %h want %h", op, R, er); end
      n_vec++; if (ERR !== exp_err) begin n_err++; $display("FAIL rand%0d_err: got %b want %b", op, ERR, exp_err); end
      release_out();
    end
  endtask

  task automatic test_back_to_back;
    int bad, lat, unstable;
    logic [W-1:0] eq, er, dsr2;
    logic [W:0]   prem;
    prem = 33'h1_FFFF_FF00;
    for (int i = 0; i < W; i++) dig_mem[i] = 2'($urandom_range(0, 1));
    dig_mem[0] = 2'b01;
    model(32'h0000_1234, prem);
    drive_start(32'h0000_1234);
    send_digits(W, prem, 1'b1, 1'b0, bad);
    wait_out(lat);
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      if (OUT_VALID !== 1'b1 || Q !== eq || R !== er || ERR !== exp_err) unstable++;
      tick();
    end
    n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL backpressure_hold: got %0d bad cycles want 0 (Q=%h want %h)", unstable, Q, eq); end
    dsr2 = 32'd21;
    set_digits_74_21();
    model(dsr2, 33'd11);
    OUT_READY = 1'b1;
    START     = 1'b1;
    DSR       = dsr2;
    tick();
    OUT_READY = 1'b0;
    START     = 1'b0;
    n_vec++; if (DIG_READY !== 1'b1) begin n_err++; $display("FAIL b2b_conv_direct: got dig_ready=%b want 1", DIG_READY); end
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop: got %b want 0", OUT_VALID); end
    send_digits(W, 33'd11, 1'b0, 1'b0, bad);
    wait_out(lat);
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL b2b_latency: got %0d want 1", lat); end
    n_vec++; if (Q !== eq) begin n_err++; $display("FAIL b2b_q: got %h want %h", Q, eq); end
    n_vec++; if (R !== er) begin n_err++; $display("FAIL b2b_r: got %h want %h", R, er); end
    release_out();
  endtask

  task automatic test_illegal;
    int bad, lat;
    for (int i = 0; i < W; i++) dig_mem[i] = 2'b00;
    dig_mem[5] = 2'b10;
    drive_start(32'd7);
    send_digits(W, 33'd0, 1'b0, 1'b0, bad);
    wait_out(lat);
    n_vec++; if (Q !== '0) begin n_err++; $display("FAIL illegal_q: got %h want 0", Q); end
    n_vec++; if (ERR !== 1'b1) begin n_err++; $display("FAIL illegal_err_set: got %b want 1", ERR); end
    n_vec++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL illegal_valid: got %b want 1", OUT_VALID); end
    release_out();
    dig_mem[5] = 2'b00;
    drive_start(32'd9);
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL illegal_err_clear: got %b want 0", ERR); end
    send_digits(W, 33'd0, 1'b0, 1'b0, bad);
    wait_out(lat);
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL illegal_err_next_op: got %b want 0", ERR); end
    release_out();
  endtask

  task automatic test_reset_mid;
    int bad, lat, spurious;
    set_digits_74_21();
    drive_start(32'd21);
    send_digits(16, 33'd11, 1'b0, 1'b0, bad);
    RST = 1'b1; START = 1'b1; DIG_VALID = 1'b1; OUT_READY = 1'b1;
    tick();
    RST = 1'b0; START = 1'b0; DIG_VALID = 1'b0; OUT_READY = 1'b0;
    n_vec++; if (DIG_READY !== 1'b0) begin n_err++; $display("FAIL rstmid_dig_ready: got %b want 0", DIG_READY); end
    n_vec++; if (Q !== '0 || R !== '0) begin n_err++; $display("FAIL rstmid_qr: got Q=%h R=%h want 0", Q, R); end
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL rstmid_err: got %b want 0", ERR); end
    spurious = 0;
    for (int k = 0; k < 20; k++) begin
      if (OUT_VALID !== 1'b0) spurious++;
      tick();
    end
    n_vec++; if (spurious !== 0) begin n_err++; $display("FAIL rstmid_no_valid: got %0d valid cycles want 0", spurious); end
    model(32'd21, 33'd11);
    drive_start(32'd21);
    send_digits(W, 33'd11, 1'b1, 1'b0, bad);
    wait_out(lat);
    n_vec++; if (Q !== exp_q.pop_front()) begin n_err++; $display("FAIL rstmid_fresh_q: got %0d want 3", Q); end
    n_vec++; if (R !== exp_q.pop_front()) begin n_err++; $display("FAIL rstmid_fresh_r: got %0d want 11", R); end
    release_out();
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; DIG_VALID = 1'b0; OUT_READY = 1'b0;
    DSR = '0; DIG = 2'b00; PREM = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
